can_tx_scheduler: RTL and testbench

CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

---
 rtl/can_tx_scheduler_if.sv | 38 +++
 rtl/can_tx_scheduler.sv | 163 ++++++++++++++++
 tb/tb_can_tx_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_tx_scheduler_if.sv
// Purpose: bundles the host mailbox port and the transmitter/bus-monitor port of the CAN TX scheduler.
// Latency: none, wiring only.
// Backpressure: none; the host learns of rejected writes through wr_err.
interface can_tx_scheduler_if;
    // host side
    logic        mb_wr_en;
    logic [1:0]  mb_wr_sel;
    logic [79:0] mb_wr_data;
    logic [3:0]  mb_abort;
    logic [3:0]  mb_pending;
    logic [3:0]  mb_done;
    logic [3:0]  mb_lost;
    logic [3:0]  mb_aborted;
    logic        wr_err;
    // transmitter / bus side
    logic        sample_point;
    logic        bus_idle;
    logic        tx_done;
    logic        arb_lost;
    logic [79:0] tx_frame;
    logic        start_tx;
    logic        busy;
    logic [1:0]  cur_mb;

    modport master (
        output mb_wr_en, mb_wr_sel, mb_wr_data, mb_abort,
        output sample_point, bus_idle, tx_done, arb_lost,
        input  mb_pending, mb_done, mb_lost, mb_aborted, wr_err,
        input  tx_frame, start_tx, busy, cur_mb
    );

    modport slave (
        input  mb_wr_en, mb_wr_sel, mb_wr_data, mb_abort,
        input  sample_point, bus_idle, tx_done, arb_lost,
        output mb_pending, mb_done, mb_lost, mb_aborted, wr_err,
        output tx_frame, start_tx, busy, cur_mb
    );
endinterface

// File: rtl/can_tx_scheduler.sv
// Purpose: holds transmit mailboxes, picks the lowest-ID pending one, hands it to the CAN transmitter.
// Latency: write -> pending 1 clk; pending+bus_idle -> SELECT 1 clk; SELECT -> START 1 clk; start_tx on next sample_point.
// Backpressure: a write to the mailbox the transmitter owns is dropped and flagged with a one-clock wr_err.
module can_tx_scheduler #(
    parameter int NUM_MB = 4
) (
    input logic               clk,
    input logic               rst,
    can_tx_scheduler_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SELECT, START, WAIT} state_t;

    state_t            state_q, state_d;
    logic [79:0]       mb_q [NUM_MB];
    logic [79:0]       mb_d [NUM_MB];
    logic [NUM_MB-1:0] pend_q, pend_d;
    logic [NUM_MB-1:0] done_q, done_d;
    logic [NUM_MB-1:0] lost_q, lost_d;
    logic [NUM_MB-1:0] abrt_q, abrt_d;
    logic              wr_err_q, wr_err_d;
    logic [79:0]       frame_q, frame_d;
    logic [1:0]        cur_q, cur_d;
    logic              abort_flag_q, abort_flag_d;
    logic              start_tx_c;
    logic              owned;

    logic [NUM_MB-1:0] cand;
    logic              win_vld;
    logic [1:0]        win_idx;
    logic [11:0]       win_key;

    // Arbitration: lowest {ID, RTR} among pending mailboxes not being aborted this clock; ties keep the lower index.
    always_comb begin
        cand    = pend_q & ~bus.mb_abort;
        win_vld = 1'b0;
        win_idx = 2'd0;
        win_key = 12'hfff;
        for (int i = 0; i < NUM_MB; i++) begin
            if (cand[i] && (!win_vld || (mb_q[i][79:68] < win_key))) begin
                win_vld = 1'b1;
                win_idx = 2'(i);
                win_key = mb_q[i][79:68];
            end
        end
    end

    // Next-state: host writes/aborts, then the FSM owning cur_mb overrides its mailbox's flags.
    always_comb begin
        state_d      = state_q;
        mb_d         = mb_q;
        pend_d       = pend_q;
        frame_d      = frame_q;
        cur_d        = cur_q;
        abort_flag_d = abort_flag_q;
        done_d       = '0;
        lost_d       = '0;
        abrt_d       = '0;
        wr_err_d     = 1'b0;
        start_tx_c   = 1'b0;
        owned        = (state_q == START) || (state_q == WAIT);

        // A write racing an abort of the same mailbox is dropped: the abort wins.
        if (bus.mb_wr_en) begin
            if (owned && (bus.mb_wr_sel == cur_q)) begin
                wr_err_d = 1'b1;
            end else if (!bus.mb_abort[bus.mb_wr_sel]) begin
                mb_d[bus.mb_wr_sel]   = bus.mb_wr_data;
                pend_d[bus.mb_wr_sel] = 1'b1;
            end
        end

        // Aborts of mailboxes the transmitter does not own take effect at once.
        for (int i = 0; i < NUM_MB; i++) begin
            if (bus.mb_abort[i] && !(owned && (2'(i) == cur_q))) begin
                pend_d[i] = 1'b0;
                abrt_d[i] = pend_q[i];
            end
        end

        case (state_q)
            IDLE: begin
                if ((|pend_q) && bus.bus_idle) state_d = SELECT;
            end
            SELECT: begin
                if (win_vld) begin
                    cur_d   = win_idx;
                    frame_d = mb_q[win_idx];
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bus.mb_abort[cur_q]) begin
                    pend_d[cur_q] = 1'b0;
                    abrt_d[cur_q] = 1'b1;
                    state_d       = IDLE;
                end else if (bus.sample_point) begin
                    start_tx_c = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (bus.mb_abort[cur_q]) abort_flag_d = 1'b1;
                if (bus.sample_point && bus.tx_done) begin
                    pend_d[cur_q] = 1'b0;
                    done_d[cur_q] = 1'b1;
                    abort_flag_d  = 1'b0;
                    state_d       = IDLE;
                end else if (bus.sample_point && bus.arb_lost) begin
                    if (abort_flag_q || bus.mb_abort[cur_q]) begin
                        pend_d[cur_q] = 1'b0;
                        abrt_d[cur_q] = 1'b1;
                    end else begin
                        lost_d[cur_q] = 1'b1;
                    end
                    abort_flag_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and mailbox registers; reset clears everything including mailbox contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < NUM_MB; i++) mb_q[i] <= '0;
            pend_q       <= '0;
            done_q       <= '0;
            lost_q       <= '0;
            abrt_q       <= '0;
            wr_err_q     <= 1'b0;
            frame_q      <= '0;
            cur_q        <= 2'd0;
            abort_flag_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < NUM_MB; i++) mb_q[i] <= mb_d[i];
            pend_q       <= pend_d;
            done_q       <= done_d;
            lost_q       <= lost_d;
            abrt_q       <= abrt_d;
            wr_err_q     <= wr_err_d;
            frame_q      <= frame_d;
            cur_q        <= cur_d;
            abort_flag_q <= abort_flag_d;
        end
    end

    assign bus.tx_frame   = frame_q;
    assign bus.start_tx   = start_tx_c;
    assign bus.busy       = (state_q != IDLE);
    assign bus.cur_mb     = cur_q;
    assign bus.mb_pending = pend_q;
    assign bus.mb_done    = done_q;
    assign bus.mb_lost    = lost_q;
    assign bus.mb_aborted = abrt_q;
    assign bus.wr_err     = wr_err_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Purpose: directed bench for can_tx_scheduler with an event scoreboard.
// Latency: expected events are queued before the stimulus that causes them and popped as the DUT emits them.
// Backpressure: exercises rejected writes to the owned mailbox.
module tb_can_tx_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    can_tx_scheduler_if ifc();

    can_tx_scheduler #(.NUM_MB(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    localparam logic [2:0] EV_START = 3'd1;
    localparam logic [2:0] EV_DONE  = 3'd2;
    localparam logic [2:0] EV_LOST  = 3'd3;
    localparam logic [2:0] EV_ABRT  = 3'd4;
    localparam logic [2:0] EV_WRERR = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [1:0]  mb;
        logic [79:0] frame;
    } ev_t;

    ev_t         exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [79:0] shadow [4];

    task automatic check(input string tag, input logic [84:0] obs, input logic [84:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] mkf(input logic [10:0] id, input logic rtr, input logic [63:0] pl);
        return {id, rtr, 4'd8, pl};
    endfunction

    task automatic expect_ev(input logic [2:0] kind, input logic [1:0] mb, input logic [79:0] frame);
        ev_t e;
        e.kind  = kind;
        e.mb    = mb;
        e.frame = frame;
        exp_q.push_back(e);
    endtask

    task automatic take(input ev_t obs);
        n_cmp++;
        assert (exp_q.size() > 0) else begin
            n_err++;
            $error("FAIL unexpected_event: observed %0h expected none", obs);
        end
        if (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_cmp--;
            check("event", obs, e);
        end
    endtask

    // Monitor: every start_tx and event pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ifc.start_tx === 1'b1) take({EV_START, ifc.cur_mb, ifc.tx_frame});
        for (int i = 0; i < 4; i++) begin
            if (ifc.mb_done[i] === 1'b1)    take({EV_DONE, 2'(i), 80'h0});
            if (ifc.mb_lost[i] === 1'b1)    take({EV_LOST, 2'(i), 80'h0});
            if (ifc.mb_aborted[i] === 1'b1) take({EV_ABRT, 2'(i), 80'h0});
        end
        if (ifc.wr_err === 1'b1) take({EV_WRERR, 2'd0, 80'h0});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [79:0] data, input bit accepted);
        ifc.mb_wr_en   = 1'b1;
        ifc.mb_wr_sel  = sel;
        ifc.mb_wr_data = data;
        tick();
        ifc.mb_wr_en   = 1'b0;
        if (accepted) shadow[sel] = data;
    endtask

    task automatic sp(input logic dn, input logic lo);
        ifc.sample_point = 1'b1;
        ifc.tx_done      = dn;
        ifc.arb_lost     = lo;
        tick();
        ifc.sample_point = 1'b0;
        ifc.tx_done      = 1'b0;
        ifc.arb_lost     = 1'b0;
    endtask

    task automatic abort_pulse(input logic [3:0] m);
        ifc.mb_abort = m;
        tick();
        ifc.mb_abort = 4'b0;
    endtask

    // From IDLE with a pending mailbox and bus_idle high: SELECT, START (one idle sample), then start_tx.
    task automatic launch(input logic [1:0] mb);
        tick();
        tick();
        check("busy_in_start", ifc.busy, 1'b1);
        tick();
        expect_ev(EV_START, mb, shadow[mb]);
        sp(1'b0, 1'b0);
        check("cur_mb", ifc.cur_mb, mb);
        check("tx_frame", ifc.tx_frame, shadow[mb]);
    endtask

    task automatic finish_ok(input logic [1:0] mb);
        expect_ev(EV_DONE, mb, 80'h0);
        sp(1'b1, 1'b0);
    endtask

    initial begin
        ifc.sample_point = 1'b0;
        ifc.bus_idle     = 1'b0;
        ifc.mb_wr_en     = 1'b0;
        ifc.mb_wr_sel    = 2'd0;
        ifc.mb_wr_data   = 80'h0;
        ifc.mb_abort     = 4'b0;
        ifc.tx_done      = 1'b0;
        ifc.arb_lost     = 1'b0;
        for (int i = 0; i < 4; i++) shadow[i] = 80'h0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pending", ifc.mb_pending, 4'b0);
        check("rst_busy", ifc.busy, 1'b0);
        check("rst_start_tx", ifc.start_tx, 1'b0);
        check("rst_tx_frame", ifc.tx_frame, 80'h0);
        check("rst_cur_mb", ifc.cur_mb, 2'd0);
        check("rst_events", {ifc.mb_done, ifc.mb_lost, ifc.mb_aborted, ifc.wr_err}, 13'h0);
        rst = 1'b0;
        tick();

        // single frame from mb2
        ifc.bus_idle = 1'b1;
        wr(2'd2, mkf(11'h123, 1'b0, 64'h1122334455667788), 1'b1);
        check("pend_after_wr", ifc.mb_pending, 4'b0100);
        launch(2'd2);
        finish_ok(2'd2);
        check("pend_after_done", ifc.mb_pending, 4'b0000);
        check("idle_after_done", ifc.busy, 1'b0);

        // lower ID first
        ifc.bus_idle = 1'b0;
        wr(2'd0, mkf(11'h200, 1'b0, 64'hA0A0A0A0A0A0A0A0), 1'b1);
        wr(2'd3, mkf(11'h100, 1'b0, 64'hB3B3B3B3B3B3B3B3), 1'b1);
        check("pend_two", ifc.mb_pending, 4'b1001);
        ifc.bus_idle = 1'b1;
        launch(2'd3);
        finish_ok(2'd3);
        launch(2'd0);
        finish_ok(2'd0);

        // equal IDs: lower index first
        ifc.bus_idle = 1'b0;
        wr(2'd2, mkf(11'h055, 1'b0, 64'h2222222222222222), 1'b1);
        wr(2'd1, mkf(11'h055, 1'b0, 64'h1111111111111111), 1'b1);
        ifc.bus_idle = 1'b1;
        launch(2'd1);
        finish_ok(2'd1);
        launch(2'd2);
        finish_ok(2'd2);

        // same ID: data frame beats remote frame even at a higher index
        ifc.bus_idle = 1'b0;
        wr(2'd0, mkf(11'h0AA, 1'b1, 64'h0), 1'b1);
        wr(2'd3, mkf(11'h0AA, 1'b0, 64'hDDDDDDDDDDDDDDDD), 1'b1);
        ifc.bus_idle = 1'b1;
        launch(2'd3);
        finish_ok(2'd3);
        launch(2'd0);
        finish_ok(2'd0);

        // arbitration lost, re-arbitration with a newly written higher-priority mailbox
        ifc.bus_idle = 1'b0;
        wr(2'd1, mkf(11'h300, 1'b0, 64'h3030303030303030), 1'b1);
        ifc.bus_idle = 1'b1;
        launch(2'd1);
        ifc.bus_idle = 1'b0;
        expect_ev(EV_LOST, 2'd1, 80'h0);
        sp(1'b0, 1'b1);
        check("pend_after_lost", ifc.mb_pending, 4'b0010);
        check("idle_after_lost", ifc.busy, 1'b0);
        wr(2'd0, mkf(11'h010, 1'b0, 64'h0101010101010101), 1'b1);
        tick();
        check("hold_while_bus_busy", ifc.busy, 1'b0);
        ifc.bus_idle = 1'b1;
        launch(2'd0);
        finish_ok(2'd0);
        launch(2'd1);
        expect_ev(EV_DONE, 2'd1, 80'h0);
        sp(1'b1, 1'b1);
        check("pend_done_beats_lost", ifc.mb_pending, 4'b0000);

        // abort of a pending non-current mailbox, and of a mailbox that is not pending
        ifc.bus_idle = 1'b0;
        wr(2'd3, mkf(11'h033, 1'b0, 64'h3333333333333333), 1'b1);
        wr(2'd0, mkf(11'h044, 1'b0, 64'h4444444444444444), 1'b1);
        check("pend_before_abort", ifc.mb_pending, 4'b1001);
        expect_ev(EV_ABRT, 2'd3, 80'h0);
        abort_pulse(4'b1000);
        check("pend_after_abort", ifc.mb_pending, 4'b0001);
        abort_pulse(4'b0100);
        check("pend_abort_idle_mb", ifc.mb_pending, 4'b0001);

        // abort of the current mailbox in START, with a sample_point on the same clock
        ifc.bus_idle = 1'b1;
        tick();
        tick();
        expect_ev(EV_ABRT, 2'd0, 80'h0);
        ifc.mb_abort     = 4'b0001;
        ifc.sample_point = 1'b1;
        tick();
        ifc.mb_abort     = 4'b0;
        ifc.sample_point = 1'b0;
        check("idle_after_start_abort", ifc.busy, 1'b0);
        check("pend_after_start_abort", ifc.mb_pending, 4'b0000);

        // write and abort to the same mailbox on one clock: abort wins
        ifc.bus_idle   = 1'b0;
        ifc.mb_wr_en   = 1'b1;
        ifc.mb_wr_sel  = 2'd2;
        ifc.mb_wr_data = mkf(11'h077, 1'b0, 64'h7);
        ifc.mb_abort   = 4'b0100;
        tick();
        ifc.mb_wr_en   = 1'b0;
        ifc.mb_abort   = 4'b0;
        check("pend_wr_abort_race", ifc.mb_pending, 4'b0000);

        // abort in WAIT, then tx_done: reported as done
        ifc.bus_idle = 1'b1;
        wr(2'd2, mkf(11'h222, 1'b0, 64'h2020202020202020), 1'b1);
        launch(2'd2);
        abort_pulse(4'b0100);
        check("pend_abort_in_wait", ifc.mb_pending, 4'b0100);
        finish_ok(2'd2);
        check("pend_abort_then_done", ifc.mb_pending, 4'b0000);

        // abort in WAIT, then arb_lost: reported as aborted
        wr(2'd1, mkf(11'h111, 1'b0, 64'h1010101010101010), 1'b1);
        launch(2'd1);
        abort_pulse(4'b0010);
        expect_ev(EV_ABRT, 2'd1, 80'h0);
        sp(1'b0, 1'b1);
        check("pend_abort_then_lost", ifc.mb_pending, 4'b0000);

        // write to the owned mailbox is rejected; other mailboxes still accept
        wr(2'd3, mkf(11'h003, 1'b0, 64'hCAFECAFECAFECAFE), 1'b1);
        launch(2'd3);
        expect_ev(EV_WRERR, 2'd0, 80'h0);
        wr(2'd3, mkf(11'h7FF, 1'b1, 64'hFFFFFFFFFFFFFFFF), 1'b0);
        check("frame_kept_on_wr_err", ifc.tx_frame, shadow[3]);
        wr(2'd0, mkf(11'h400, 1'b0, 64'h4040404040404040), 1'b1);
        check("pend_other_wr_in_wait", ifc.mb_pending, 4'b1001);
        finish_ok(2'd3);
        launch(2'd0);
        finish_ok(2'd0);

        // reset in WAIT: outputs clear immediately, no event, nothing restarts
        wr(2'd2, mkf(11'h0F0, 1'b0, 64'h0F0F0F0F0F0F0F0F), 1'b1);
        launch(2'd2);
        ifc.sample_point = 1'b1;
        ifc.tx_done      = 1'b1;
        rst              = 1'b1;
        #1;
        check("arst_pending", ifc.mb_pending, 4'b0);
        check("arst_busy", ifc.busy, 1'b0);
        check("arst_start_tx", ifc.start_tx, 1'b0);
        check("arst_tx_frame", ifc.tx_frame, 80'h0);
        check("arst_cur_mb", ifc.cur_mb, 2'd0);
        tick();
        ifc.sample_point = 1'b0;
        ifc.tx_done      = 1'b0;
        rst              = 1'b0;
        repeat (3) tick();
        check("no_restart_after_rst", ifc.busy, 1'b0);
        check("no_pending_after_rst", ifc.mb_pending, 4'b0);

        repeat (2) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
